// File: rtl/load_store_unit.sv
// Load/store initiator for a word-only data memory: sub-word loads by extract/extend,
// sub-word stores by read-modify-write, misaligned/illegal requests answered with an error.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // IDLE   | waiting for a request, req_ready high
  // LOAD   | mem_read, extract/extend result into rdata_q
  // RMW_RD | mem_read of the word a SB/SH will patch
  // WRITE  | mem_write of full word (SW data or patched word)
  // DONE   | successful response pulse
  // ERR    | error response pulse, no memory access made
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;

  logic        req_legal;
  logic        req_misaligned;
  logic [31:0] load_word;
  logic [31:0] merged_word;
  logic [4:0]  byte_sh;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    req_legal = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Little-endian lane select; bit 2 of funct3 chooses zero- over sign-extension.
  always_comb begin
    byte_sh  = {addr_q[1:0], 3'b000};
    sel_byte = mem_rdata[byte_sh +: 8];
    sel_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_word = {{24{sel_byte[7] & ~funct3_q[2]}}, sel_byte};
      2'b01:   load_word = {{16{sel_half[15] & ~funct3_q[2]}}, sel_half};
      default: load_word = mem_rdata;
    endcase
  end

  always_comb begin
    merged_word = old_q;
    case (funct3_q[1:0])
      2'b00: merged_word[byte_sh +: 8] = wdata_q[7:0];
      2'b01: begin
        if (addr_q[1]) merged_word[31:16] = wdata_q[15:0];
        else           merged_word[15:0]  = wdata_q[15:0];
      end
      default: merged_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      old_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wdata_q  <= req_wdata;
            write_q  <= req_write;
            rdata_q  <= '0;
            if (!req_legal || req_misaligned) state <= S_ERR;
            else if (!req_write)               state <= S_LOAD;
            else if (req_funct3 == 3'b010)     state <= S_WRITE;
            else                               state <= S_RMW_RD;
          end
        end
        S_LOAD: begin
          rdata_q <= load_word;
          state   <= S_DONE;
        end
        S_RMW_RD: begin
          old_q <= mem_rdata;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so an in-flight strobe never reaches memory during reset.
  always_comb begin
    req_ready  = !rst && (state == S_IDLE);
    mem_read   = !rst && ((state == S_LOAD) || (state == S_RMW_RD));
    mem_write  = !rst && (state == S_WRITE) && write_q;
    mem_funct3 = 3'b010;
    mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata  = mem_write ? merged_word : 32'h0;
    resp_valid = !rst && ((state == S_DONE) || (state == S_ERR));
    resp_err   = !rst && (state == S_ERR);
    resp_rdata = (!rst && (state == S_DONE)) ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model attached.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:15];
  logic        poke;
  logic [3:0]  poke_idx;
  logic [31:0] poke_val;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          rv_cnt = 0;

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_addr[5:2]] <= mem_wdata;
    else if (poke)  mem[poke_idx] <= poke_val;
    if (mem_write)  wr_cnt <= wr_cnt + 1;
    if (mem_read)   rd_cnt <= rd_cnt + 1;
    if (resp_valid) rv_cnt <= rv_cnt + 1;
  end

  // Per-cycle observations T+1..T+4 of the most recent transaction.
  logic        ready_pre;
  logic        c_rd [1:4];
  logic        c_wr [1:4];
  logic        c_rv [1:4];
  logic        c_err [1:4];
  logic        c_ready [1:4];
  logic [31:0] c_rdata [1:4];
  logic [31:0] c_addr [1:4];
  logic [31:0] c_wdata [1:4];

  task automatic poke_word(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clk); #1;
    poke = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d);
    @(negedge clk);
    ready_pre = req_ready;
    req_valid = 1'b1; req_write = w; req_funct3 = f; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      c_rd[k] = mem_read;     c_wr[k] = mem_write;   c_rv[k] = resp_valid;
      c_err[k] = resp_err;    c_ready[k] = req_ready;
      c_rdata[k] = resp_rdata; c_addr[k] = mem_addr; c_wdata[k] = mem_wdata;
      if (k < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    vectors++;
    if ({mem_read, mem_write, resp_valid, resp_err} !== 4'b0000) begin
      miscompares++; $display("FAIL reset_strobes got=%b want=0000", {mem_read, mem_write, resp_valid, resp_err});
    end
    vectors++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_buses addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, resp_rdata);
    end
    vectors++;
    if (mem_funct3 !== 3'b010) begin miscompares++; $display("FAIL mem_funct3 got=%b want=010", mem_funct3); end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_lw;
    poke_word(4'd4, 32'h8899AABB);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    vectors++;
    if (ready_pre !== 1'b1) begin miscompares++; $display("FAIL lw_ready_pre got=%b want=1", ready_pre); end
    vectors++;
    if ({c_rd[1], c_wr[1], c_rv[1], c_ready[1]} !== 4'b1000) begin
      miscompares++; $display("FAIL lw_t1 rd/wr/rv/rdy got=%b want=1000", {c_rd[1], c_wr[1], c_rv[1], c_ready[1]});
    end
    vectors++;
    if (c_addr[1] !== 32'h10) begin miscompares++; $display("FAIL lw_addr got=%h want=00000010", c_addr[1]); end
    vectors++;
    if ({c_rd[2], c_rv[2], c_err[2]} !== 3'b010 || c_rdata[2] !== 32'h8899AABB) begin
      miscompares++; $display("FAIL lw_t2 rd/rv/err=%b rdata=%h want 010 8899aabb", {c_rd[2], c_rv[2], c_err[2]}, c_rdata[2]);
    end
    vectors++;
    if (c_addr[2] !== 32'h0) begin miscompares++; $display("FAIL lw_idle_addr got=%h want=0", c_addr[2]); end
    vectors++;
    if ({c_rv[3], c_ready[3]} !== 2'b01 || c_rdata[3] !== 32'h0) begin
      miscompares++; $display("FAIL lw_t3 rv/rdy=%b rdata=%h want 01 0", {c_rv[3], c_ready[3]}, c_rdata[3]);
    end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f [4]   = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] a [4]   = '{32'h13, 32'h11, 32'h12, 32'h10};
    logic [31:0] exp [4] = '{32'hFFFFFF88, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB};
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, f[i], a[i], 32'h0);
      vectors++;
      if (c_rv[2] !== 1'b1 || c_err[2] !== 1'b0 || c_rdata[2] !== exp[i]) begin
        miscompares++;
        $display("FAIL subword_load[%0d] rv=%b err=%b rdata=%h want 1 0 %h", i, c_rv[2], c_err[2], c_rdata[2], exp[i]);
      end
    end
  endtask

  task automatic test_sb;
    int w0;
    w0 = wr_cnt;
    issue(1'b1, 3'b000, 32'h11, 32'h12345677);
    vectors++;
    if ({c_rd[1], c_wr[1]} !== 2'b10 || c_addr[1] !== 32'h10) begin
      miscompares++; $display("FAIL sb_t1 rd/wr=%b addr=%h want 10 00000010", {c_rd[1], c_wr[1]}, c_addr[1]);
    end
    vectors++;
    if ({c_rd[2], c_wr[2]} !== 2'b01 || c_wdata[2] !== 32'h889977BB || c_addr[2] !== 32'h10) begin
      miscompares++; $display("FAIL sb_t2 rd/wr=%b wdata=%h addr=%h want 01 889977bb 00000010", {c_rd[2], c_wr[2]}, c_wdata[2], c_addr[2]);
    end
    vectors++;
    if ({c_rv[3], c_err[3]} !== 2'b10 || c_rdata[3] !== 32'h0 || c_rv[2] !== 1'b0) begin
      miscompares++; $display("FAIL sb_resp rv3/err3=%b rdata=%h rv2=%b want 10 0 0", {c_rv[3], c_err[3]}, c_rdata[3], c_rv[2]);
    end
    vectors++;
    if (c_ready[4] !== 1'b1 || c_ready[3] !== 1'b0) begin
      miscompares++; $display("FAIL sb_ready rdy3=%b rdy4=%b want 0 1", c_ready[3], c_ready[4]);
    end
    vectors++;
    if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL sb_write_count got=%0d want=1", wr_cnt - w0); end
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    vectors++;
    if (c_rdata[2] !== 32'h889977BB) begin miscompares++; $display("FAIL sb_readback got=%h want=889977bb", c_rdata[2]); end
  endtask

  task automatic test_sh_sw;
    int w0, r0;
    poke_word(4'd4, 32'h8899AABB);
    issue(1'b1, 3'b001, 32'h12, 32'h0000CAFE);
    vectors++;
    if (c_wr[2] !== 1'b1 || c_wdata[2] !== 32'hCAFEAABB) begin
      miscompares++; $display("FAIL sh_wdata wr=%b wdata=%h want 1 cafeaabb", c_wr[2], c_wdata[2]);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    vectors++;
    if (c_rdata[2] !== 32'hCAFEAABB) begin miscompares++; $display("FAIL sh_readback got=%h want=cafeaabb", c_rdata[2]); end
    w0 = wr_cnt; r0 = rd_cnt;
    issue(1'b1, 3'b010, 32'h14, 32'hDEADBEEF);
    vectors++;
    if ({c_rd[1], c_wr[1]} !== 2'b01 || c_wdata[1] !== 32'hDEADBEEF || c_addr[1] !== 32'h14) begin
      miscompares++; $display("FAIL sw_t1 rd/wr=%b wdata=%h addr=%h want 01 deadbeef 00000014", {c_rd[1], c_wr[1]}, c_wdata[1], c_addr[1]);
    end
    vectors++;
    if ({c_rv[2], c_err[2], c_wr[2]} !== 3'b100 || c_rdata[2] !== 32'h0) begin
      miscompares++; $display("FAIL sw_resp rv/err/wr=%b rdata=%h want 100 0", {c_rv[2], c_err[2], c_wr[2]}, c_rdata[2]);
    end
    vectors++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL sw_counts writes=%0d reads=%0d want 1 0", wr_cnt - w0, rd_cnt - r0);
    end
    issue(1'b0, 3'b010, 32'h14, 32'h0);
    vectors++;
    if (c_rdata[2] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_readback got=%h want=deadbeef", c_rdata[2]); end
  endtask

  task automatic test_errors;
    logic        w [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f [4] = '{3'b010, 3'b001, 3'b011, 3'b110};
    logic [31:0] a [4] = '{32'h12, 32'h13, 32'h10, 32'h10};
    int w0, r0;
    for (int i = 0; i < 4; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      issue(w[i], f[i], a[i], 32'hFFFFFFFF);
      vectors++;
      if ({c_rv[1], c_err[1]} !== 2'b11 || c_rdata[1] !== 32'h0) begin
        miscompares++; $display("FAIL err_resp[%0d] rv/err=%b rdata=%h want 11 0", i, {c_rv[1], c_err[1]}, c_rdata[1]);
      end
      vectors++;
      if (wr_cnt - w0 !== 0 || rd_cnt - r0 !== 0 || c_rv[2] !== 1'b0 || c_ready[2] !== 1'b1) begin
        miscompares++; $display("FAIL err_quiet[%0d] writes=%0d reads=%0d rv2=%b rdy2=%b want 0 0 0 1",
                                i, wr_cnt - w0, rd_cnt - r0, c_rv[2], c_ready[2]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] rd_seq, rv_seq, rdy_seq;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    @(posedge clk);
    for (int k = 5; k >= 0; k--) begin
      #1;
      rd_seq[k] = mem_read; rv_seq[k] = resp_valid; rdy_seq[k] = req_ready;
      if (k > 0) @(posedge clk);
    end
    req_valid = 1'b0;
    vectors++;
    if (rd_seq !== 6'b100100 || rv_seq !== 6'b010010 || rdy_seq !== 6'b001001) begin
      miscompares++; $display("FAIL back_to_back rd=%b rv=%b rdy=%b want 100100 010010 001001", rd_seq, rv_seq, rdy_seq);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_rmw;
    int w0, v0;
    poke_word(4'd4, 32'h8899AABB);
    w0 = wr_cnt; v0 = rv_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clk); #1;
    vectors++;
    if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rst_rmw_rd got=%b want=1", mem_read); end
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++; $display("FAIL rst_gate rdy=%b rd=%b want 0 0", req_ready, mem_read);
    end
    @(posedge clk); #1;
    vectors++;
    if ({req_ready, mem_write, resp_valid} !== 3'b000) begin
      miscompares++; $display("FAIL rst_hold rdy/wr/rv=%b want 000", {req_ready, mem_write, resp_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_after_ready got=%b want=1", req_ready); end
    @(posedge clk); #1;
    vectors++;
    if ({mem_read, mem_write, req_ready} !== 3'b001) begin
      miscompares++; $display("FAIL rst_no_accept rd/wr/rdy=%b want 001", {mem_read, mem_write, req_ready});
    end
    vectors++;
    if (wr_cnt - w0 !== 0 || rv_cnt - v0 !== 0) begin
      miscompares++; $display("FAIL rst_no_activity writes=%0d resps=%0d want 0 0", wr_cnt - w0, rv_cnt - v0);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    vectors++;
    if (c_rdata[2] !== 32'h8899AABB) begin miscompares++; $display("FAIL rst_mem_unchanged got=%h want=8899aabb", c_rdata[2]); end
  endtask

  initial begin
    rst = 1'b1; poke = 1'b0; poke_idx = '0; poke_val = '0;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset;
    test_lw;
    test_subword_loads;
    test_sb;
    test_sh_sw;
    test_errors;
    test_back_to_back;
    test_reset_mid_rmw;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
